// File: rtl/eth_pll_lock_supervisor.sv
// Ethernet PLL supervisor: sequences the PLL reset, qualifies the asynchronous lock
// flag, retries on lock timeout and produces the Ethernet-domain reset/ready.
module eth_pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 125000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRIES      = 7,
  parameter int LOSS_CNT_W       = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  retry_req,
  input  logic                  clr_stats,
  output logic                  pll_rst,
  output logic                  eth_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [3:0]            retry_cnt,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int CNT_MAX0 = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int CNT_MAX  = (CNT_MAX0 > LOCK_STABLE_CYC) ? CNT_MAX0 : LOCK_STABLE_CYC;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {S_PLLRST, S_WAIT, S_STABLE, S_RUN, S_FAULT} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            retry_q, retry_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic [1:0]            sync_q;
  logic                  locked_s;
  logic                  loss_inc;
  logic                  pll_rst_q, pll_rst_d;
  logic                  eth_rst_q, eth_rst_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      eth_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      sync_q    <= {sync_q[0], pll_locked};
      pll_rst_q <= pll_rst_d;
      eth_rst_q <= eth_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // One shared counter serves the reset pulse, the lock timeout and the stability window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    loss_inc = 1'b0;
    case (state_q)
      S_PLLRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WAIT: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          retry_d = retry_q + 4'd1;
          state_d = (retry_q + 4'd1 == RETRY_LIMIT) ? S_FAULT : S_PLLRST;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_RUN: begin
        retry_d = '0;
        cnt_d   = '0;
        if (!locked_s) begin
          state_d  = S_PLLRST;
          loss_inc = 1'b1;
        end
      end
      S_FAULT: begin
        cnt_d = '0;
        if (retry_req) begin
          state_d = S_PLLRST;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear wins over the old value but still records a loss landing on the same edge.
  always_comb begin
    loss_d = loss_q;
    if (clr_stats)
      loss_d = loss_inc ? LOSS_CNT_W'(1) : '0;
    else if (loss_inc && (loss_q != {LOSS_CNT_W{1'b1}}))
      loss_d = loss_q + LOSS_CNT_W'(1);
  end

  // Outputs decode the next state so they move on the same edge as the transition.
  always_comb begin
    pll_rst_d = (state_d == S_PLLRST) || (state_d == S_FAULT);
    eth_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  assign pll_rst       = pll_rst_q;
  assign eth_rst       = eth_rst_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule
